// File: rtl/gaussian_pkg.sv
// gaussian_pkg: shared kernel weights, normalisation constants and pixel type for the blur stage
package gaussian_pkg;
  localparam int PIX_W = 8;
  localparam int K_CORNER = 1;
  localparam int K_EDGE = 2;
  localparam int K_CENTRE = 4;
  localparam int NORM_SH = 4;
  localparam int ROUND_C = 1 << (NORM_SH - 1);
  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/gaussian_kernel3x3.sv
// gaussian_kernel3x3: combinational [1 2 1; 2 4 2; 1 2 1] weighted sum of a row-major 3x3 window
module gaussian_kernel3x3
  import gaussian_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [9*DW-1:0] win,
  output logic [DW+3:0]   sum
);
  localparam int SW = DW + 4;
  logic [SW-1:0] corner, edge_s, centre;
  // corners, edges and centre grouped so each group gets its own weight
  always_comb begin
    corner = SW'(win[0*DW +: DW]) + SW'(win[2*DW +: DW]) + SW'(win[6*DW +: DW]) + SW'(win[8*DW +: DW]);
    edge_s = SW'(win[1*DW +: DW]) + SW'(win[3*DW +: DW]) + SW'(win[5*DW +: DW]) + SW'(win[7*DW +: DW]);
    centre = SW'(win[4*DW +: DW]);
    sum = corner * SW'(K_CORNER) + edge_s * SW'(K_EDGE) + centre * SW'(K_CENTRE);
  end
endmodule

// File: rtl/gaussian_window.sv
// gaussian_window: 3x3 Gaussian blur over streamed columns; GAUSS_ROUND_EN selects round-half-up with saturation
module gaussian_window
  import gaussian_pkg::*;
#(
  parameter int W  = 9,
  parameter int H  = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [DW-1:0] top,
  input  logic [DW-1:0] mid,
  input  logic [DW-1:0] bot,
  output logic [DW-1:0] pixel_out,
  output logic          valid_out,
  output logic          frame_done
);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [3*DW-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic            v1_q, v1_d, f1_q, f1_d;
  logic [DW-1:0]   pix_q, pix_d, res;
  logic            vout_q, vout_d, done_q, done_d;
  logic            col_last, row_last;
  logic [DW+3:0]   sum;
`ifdef GAUSS_ROUND_EN
  logic [DW+4:0]   rsum;
`endif
  gaussian_kernel3x3 #(.DW(DW)) u_kernel (
    .win ({c2_q[DW-1:0], c1_q[DW-1:0], c0_q[DW-1:0],
           c2_q[2*DW-1:DW], c1_q[2*DW-1:DW], c0_q[2*DW-1:DW],
           c2_q[3*DW-1:2*DW], c1_q[3*DW-1:2*DW], c0_q[3*DW-1:2*DW]}),
    .sum (sum)
  );
  // stage 1 tracks position and shifts the window; stage 2 normalises the sum of the shifted window
  always_comb begin
    col_last = col_q == CW'(W - 1);
    row_last = row_q == RW'(H - 1);
    col_d = valid_in ? (col_last ? '0 : col_q + 1'b1) : col_q;
    row_d = (valid_in && col_last) ? (row_last ? '0 : row_q + 1'b1) : row_q;
    c0_d = valid_in ? c1_q : c0_q;
    c1_d = valid_in ? c2_q : c1_q;
    c2_d = valid_in ? {top, mid, bot} : c2_q;
    v1_d = valid_in && col_q >= CW'(2) && row_q >= RW'(2);
    f1_d = valid_in && col_last && row_last;
`ifdef GAUSS_ROUND_EN
    rsum = {1'b0, sum} + (DW+5)'(ROUND_C);
    res = rsum[DW+4] ? '1 : DW'(rsum >> NORM_SH);
`else
    res = DW'(sum >> NORM_SH);
`endif
    pix_d = v1_q ? res : pix_q;
    vout_d = v1_q;
    done_d = v1_q && f1_q;
  end
  // all state clears at once on reset so no partial result survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      c0_q <= '0;
      c1_q <= '0;
      c2_q <= '0;
      v1_q <= 1'b0;
      f1_q <= 1'b0;
      pix_q <= '0;
      vout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      c0_q <= c0_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
      v1_q <= v1_d;
      f1_q <= f1_d;
      pix_q <= pix_d;
      vout_q <= vout_d;
      done_q <= done_d;
    end
  end
  assign pixel_out = pix_q;
  assign valid_out = vout_q;
  assign frame_done = done_q;
endmodule
